gc_config_loader: RTL and testbench

GC_CONFIG_LOADER -- requirements
Module: gc_config_loader

---
 rtl/gc_config_loader.sv | 133 +++++++++++++
 tb/tb_gc_config_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gc_config_loader.sv
// gc_config_loader: parses header/payload records from the config memory stream into PE write beats.
// Optional checksum word per record is enabled with `define GC_LOADER_CHKSUM_EN.
module gc_config_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 1020
) (
    input  logic        clk,
    input  logic        gc_reset,
    input  logic        pdone,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        conf_en,
    output logic        rnready,
    output logic        config_done,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [7:0]  cfg_target,
    output logic [15:0] cfg_addr,
    output logic [31:0] cfg_data,
    output logic        cfg_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RN = FIFO_DEPTH - 2;
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] RN_CNT = RN[AW:0];
    localparam logic [15:0] MAX_W = 16'(MAX_LEN);
`ifdef GC_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHK, DONE} state_t;
    localparam state_t LAST = CHK;
    logic [31:0] csum;
`else
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DONE} state_t;
    localparam state_t LAST = HDR;
`endif
    state_t state, state_n;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp, count;
    logic [31:0] head;
    logic [15:0] cnt, len;
    logic empty, full, push, pop, drop, beat;
    logic hdr_go, hdr_err, done_set, chk_err;

    assign count = wp - rp;
    assign empty = wp == rp;
    assign full = count == FULL_CNT;
    assign head = mem[rp[AW-1:0]];
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push = din_valid && (!full || pop);
    assign drop = din_valid && full && !pop;
    assign rnready = count >= RN_CNT;
    assign cfg_valid = state == PAYLOAD && !empty;
    assign beat = cfg_valid && cfg_ready;
    assign cfg_data = cfg_valid ? head : '0;
    assign cfg_addr = cnt;
    assign conf_en = !gc_reset && state != DONE && !(state == IDLE && !pdone);

    always_comb begin
        state_n = state;
        pop = 1'b0;
        hdr_go = 1'b0;
        hdr_err = 1'b0;
        done_set = 1'b0;
        chk_err = 1'b0;
        case (state)
            IDLE: state_n = pdone ? HDR : IDLE;
            HDR: if (!empty) begin
                pop = 1'b1;
                if (head[31:24] == 8'hFF) begin
                    state_n = DONE;
                    done_set = 1'b1;
                end else if (head[15:0] == 16'd0 || head[15:0] > MAX_W) begin
                    state_n = DONE;
                    done_set = 1'b1;
                    hdr_err = 1'b1;
                end else begin
                    state_n = PAYLOAD;
                    hdr_go = 1'b1;
                end
            end
            PAYLOAD: if (beat) begin
                pop = 1'b1;
                state_n = (cnt + 16'd1 == len) ? LAST : PAYLOAD;
            end
`ifdef GC_LOADER_CHKSUM_EN
            CHK: if (!empty) begin
                pop = 1'b1;
                chk_err = head != csum;
                state_n = HDR;
            end
`endif
            DONE: state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge gc_reset) begin
        if (gc_reset) begin
            state <= IDLE;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            len <= '0;
            cfg_target <= '0;
            config_done <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state <= state_n;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            config_done <= done_set;
            if (hdr_err || drop || chk_err) cfg_error <= 1'b1;
            if (hdr_go) begin
                cnt <= '0;
                len <= head[15:0];
                cfg_target <= head[31:24];
            end else if (beat) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

`ifdef GC_LOADER_CHKSUM_EN
    always_ff @(posedge clk or posedge gc_reset) begin
        if (gc_reset) csum <= '0;
        else if (hdr_go) csum <= '0;
        else if (beat) csum <= csum ^ head;
    end
`endif
endmodule

// File: tb/tb_gc_config_loader.sv
// tb_gc_config_loader: directed checks of record parsing, backpressure, errors and reset.
module tb_gc_config_loader;
    logic        clk = 1'b0;
    logic        gc_reset, pdone, din_valid, cfg_ready;
    logic [31:0] din;
    logic        conf_en, rnready, config_done, cfg_valid, cfg_error;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_addr;
    logic [31:0] cfg_data;
    int checks = 0;
    int errors = 0;
    bit seen;

    gc_config_loader dut (
        .clk(clk), .gc_reset(gc_reset), .pdone(pdone), .din(din), .din_valid(din_valid),
        .conf_en(conf_en), .rnready(rnready), .config_done(config_done), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_target(cfg_target), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        gc_reset = 1'b1;
        pdone = 1'b0;
        din_valid = 1'b0;
        cfg_ready = 1'b1;
        tick();
        tick();
        gc_reset = 1'b0;
        #1;
        chk("post_reset_error", {31'b0, cfg_error}, 0);
    endtask

    task automatic beat(input string tag, input logic [7:0] t, input logic [15:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, {31'b0, cfg_valid}, 1);
        chk({tag, "_target"}, {24'b0, cfg_target}, {24'b0, t});
        chk({tag, "_addr"}, {16'b0, cfg_addr}, {16'b0, a});
        chk({tag, "_data"}, cfg_data, d);
    endtask

    initial begin
        gc_reset = 1'b0;
        pdone = 1'b0;
        din_valid = 1'b0;
        din = '0;
        cfg_ready = 1'b1;
        #2 gc_reset = 1'b1;
        #2;
        chk("rst_conf_en", {31'b0, conf_en}, 0);
        chk("rst_rnready", {31'b0, rnready}, 0);
        chk("rst_done", {31'b0, config_done}, 0);
        chk("rst_valid", {31'b0, cfg_valid}, 0);
        chk("rst_target", {24'b0, cfg_target}, 0);
        chk("rst_addr", {16'b0, cfg_addr}, 0);
        chk("rst_data", cfg_data, 0);
        chk("rst_error", {31'b0, cfg_error}, 0);
        do_reset();
`ifdef GC_LOADER_CHKSUM_EN
        push(32'h0200_0002); push(32'd1); push(32'd2); push(32'd3);
        pdone = 1'b1;
        tick(); tick();
        beat("ck_b0", 8'h02, 16'd0, 32'd1);
        tick();
        beat("ck_b1", 8'h02, 16'd1, 32'd2);
        tick(); tick();
        chk("ck_good_err", {31'b0, cfg_error}, 0);
        push(32'h0200_0002); push(32'd1); push(32'd2); push(32'd4); push(32'hFF00_0000);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (config_done) seen = 1'b1;
            else tick();
        end
        chk("ck_done_seen", {31'b0, seen}, 1);
        chk("ck_bad_err", {31'b0, cfg_error}, 1);
`else
        // basic two-beat record followed by end marker
        push(32'h0300_0002); push(32'hDEAD_BEEF); push(32'h1234_5678); push(32'hFF00_0000);
        chk("t1_rnready_full", {31'b0, rnready}, 1);
        chk("t1_conf_en_idle", {31'b0, conf_en}, 0);
        pdone = 1'b1;
        #1 chk("t1_conf_en_pdone", {31'b0, conf_en}, 1);
        tick();
        chk("t1_hdr_valid", {31'b0, cfg_valid}, 0);
        tick();
        beat("t1_b0", 8'h03, 16'd0, 32'hDEAD_BEEF);
        tick();
        beat("t1_b1", 8'h03, 16'd1, 32'h1234_5678);
        tick();
        chk("t1_after_valid", {31'b0, cfg_valid}, 0);
        chk("t1_done_early", {31'b0, config_done}, 0);
        tick();
        chk("t1_done", {31'b0, config_done}, 1);
        chk("t1_conf_en_done", {31'b0, conf_en}, 0);
        pdone = 1'b0;
        tick();
        chk("t1_done_pulse", {31'b0, config_done}, 0);
        pdone = 1'b1;
        tick();
        chk("t1_done_hold", {31'b0, conf_en}, 0);
        chk("t1_done_repulse", {31'b0, config_done}, 0);
        chk("t1_error", {31'b0, cfg_error}, 0);

        // stall mid-payload
        do_reset();
        push(32'h0500_0003);
        chk("t2_rn_fill1", {31'b0, rnready}, 0);
        push(32'hA0A0_0000);
        chk("t2_rn_fill2", {31'b0, rnready}, 1);
        push(32'hA1A1_1111); push(32'hA2A2_2222);
        cfg_ready = 1'b0;
        pdone = 1'b1;
        tick(); tick();
        beat("t2_first", 8'h05, 16'd0, 32'hA0A0_0000);
        din = 32'hFF00_0000;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            din_valid = 1'b0;
            beat("t2_stall", 8'h05, 16'd0, 32'hA0A0_0000);
        end
        chk("t2_rn_stall", {31'b0, rnready}, 1);
        cfg_ready = 1'b1;
        tick();
        beat("t2_b1", 8'h05, 16'd1, 32'hA1A1_1111);
        tick();
        beat("t2_b2", 8'h05, 16'd2, 32'hA2A2_2222);
        tick();
        chk("t2_after_valid", {31'b0, cfg_valid}, 0);
        tick();
        chk("t2_done", {31'b0, config_done}, 1);
        chk("t2_error", {31'b0, cfg_error}, 0);

        // zero-length header
        do_reset();
        push(32'h0100_0000);
        pdone = 1'b1;
        tick();
        chk("t3_hdr_valid", {31'b0, cfg_valid}, 0);
        tick();
        chk("t3_error", {31'b0, cfg_error}, 1);
        chk("t3_done", {31'b0, config_done}, 1);
        chk("t3_valid", {31'b0, cfg_valid}, 0);
        tick();
        chk("t3_done_pulse", {31'b0, config_done}, 0);
        chk("t3_error_sticky", {31'b0, cfg_error}, 1);

        // overflow drop, then push into full FIFO alongside a pop
        do_reset();
        cfg_ready = 1'b0;
        push(32'h0700_0003); push(32'hB0B0_0000); push(32'hB1B1_1111); push(32'hB2B2_2222);
        chk("t4_no_err_full", {31'b0, cfg_error}, 0);
        push(32'hCCCC_CCCC);
        chk("t4_drop_err", {31'b0, cfg_error}, 1);
        pdone = 1'b1;
        cfg_ready = 1'b1;
        tick();
        push(32'hFF00_0000);
        beat("t4_b0", 8'h07, 16'd0, 32'hB0B0_0000);
        tick();
        beat("t4_b1", 8'h07, 16'd1, 32'hB1B1_1111);
        tick();
        beat("t4_b2", 8'h07, 16'd2, 32'hB2B2_2222);
        tick();
        chk("t4_after_valid", {31'b0, cfg_valid}, 0);
        tick();
        chk("t4_done", {31'b0, config_done}, 1);

        // reset in the middle of a record
        do_reset();
        push(32'h0900_0003); push(32'hD0D0_0000); push(32'hD1D1_1111);
        cfg_ready = 1'b0;
        pdone = 1'b1;
        tick(); tick();
        beat("t5_pre", 8'h09, 16'd0, 32'hD0D0_0000);
        gc_reset = 1'b1;
        #1;
        chk("t5_conf_en", {31'b0, conf_en}, 0);
        chk("t5_rnready", {31'b0, rnready}, 0);
        chk("t5_done", {31'b0, config_done}, 0);
        chk("t5_valid", {31'b0, cfg_valid}, 0);
        chk("t5_target", {24'b0, cfg_target}, 0);
        chk("t5_addr", {16'b0, cfg_addr}, 0);
        chk("t5_data", cfg_data, 0);
        tick();
        pdone = 1'b0;
        gc_reset = 1'b0;
        cfg_ready = 1'b1;
        #1;
        chk("t5_idle_conf_en", {31'b0, conf_en}, 0);
        push(32'h0A00_0001); push(32'hEEEE_0001); push(32'hFF00_0000);
        pdone = 1'b1;
        tick(); tick();
        beat("t5_fresh", 8'h0A, 16'd0, 32'hEEEE_0001);
        tick();
        chk("t5_after_valid", {31'b0, cfg_valid}, 0);
        tick();
        chk("t5_fresh_done", {31'b0, config_done}, 1);
        chk("t5_fresh_error", {31'b0, cfg_error}, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
